sugar_placer: RTL and testbench



---
 rtl/sugar_placer_pkg.sv | 9 +
 rtl/sugar_placer_collision.sv | 19 +
 rtl/sugar_placer.sv | 142 ++++++++++++++
 tb/tb_sugar_placer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sugar_placer_pkg.sv
// sugar_placer_pkg: shared state encoding and LFSR constants for the sugar placer
package sugar_placer_pkg;
   typedef enum logic [2:0] {IDLE, GEN, CHECK, COMMIT, DONE} placer_state_t;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? (s >> 1) ^ LFSR_MASK : s >> 1;
   endfunction
endpackage

// File: rtl/sugar_placer_collision.sv
// collision_square: flags a hit when check lies strictly inside the square of half-width radius around obj
module collision_square #(
   parameter int XW = 10,
   parameter int YW = 9,
   parameter int RW = 16
) (
   input  logic [XW-1:0] check_x,
   input  logic [YW-1:0] check_y,
   input  logic [XW-1:0] obj_x,
   input  logic [YW-1:0] obj_y,
   input  logic [RW-1:0] radius,
   output logic          hit
);
   logic [XW-1:0] dx;
   logic [YW-1:0] dy;
   assign dx = check_x >= obj_x ? check_x - obj_x : obj_x - check_x;
   assign dy = check_y >= obj_y ? check_y - obj_y : obj_y - check_y;
   assign hit = RW'(dx) < radius && RW'(dy) < radius;
endmodule

// File: rtl/sugar_placer.sv
// sugar_placer: scatters sugar piles over the arena, rejecting candidates too close to edges,
// nests or previously placed piles using one shared square collision checker.
module sugar_placer
   import sugar_placer_pkg::*;
#(
   parameter int          NUM_SUGAR    = 8,
   parameter int          NUM_NESTS    = 2,
   parameter int          SPACING      = 24,
   parameter int          MARGIN       = 16,
   parameter int          SCREEN_W     = 640,
   parameter int          SCREEN_H     = 480,
   parameter int          MAX_ATTEMPTS = 1024,
   parameter logic [15:0] SEED         = 16'hACE1,
   localparam int         X_BITS       = $clog2(SCREEN_W),
   localparam int         Y_BITS       = $clog2(SCREEN_H)
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic                              start,
   input  logic [NUM_NESTS-1:0][X_BITS-1:0] nest_x,
   input  logic [NUM_NESTS-1:0][Y_BITS-1:0] nest_y,
   output logic                              busy,
   output logic                              done,
   output logic                              fail,
   output logic [NUM_SUGAR-1:0][X_BITS-1:0] sugar_x,
   output logic [NUM_SUGAR-1:0][Y_BITS-1:0] sugar_y,
   output logic [NUM_SUGAR-1:0]              sugar_valid,
   output logic [4:0]                        placed
);
   localparam int AW = $clog2(MAX_ATTEMPTS) + 1;
   localparam logic [15:0] SEED_R = SEED == 16'd0 ? DEFAULT_SEED : SEED;

   placer_state_t     state;
   logic [15:0]       lfsr, lfsr_n;
   logic [X_BITS-1:0] cx, nx, ox;
   logic [Y_BITS-1:0] cy, ny, oy;
   logic [AW-1:0]     attempts;
   logic [4:0]        obj_idx;
   logic              hit, is_hit, edge_bad, last_obj;

   assign lfsr_n = lfsr_next(lfsr);
   assign nx = lfsr_n[X_BITS-1:0];
   assign ny = lfsr_n[15 -: Y_BITS];
   assign edge_bad = {1'b0, nx} <  (X_BITS+1)'(MARGIN)
                  || {1'b0, nx} >= (X_BITS+1)'(SCREEN_W - MARGIN)
                  || {1'b0, ny} <  (Y_BITS+1)'(MARGIN)
                  || {1'b0, ny} >= (Y_BITS+1)'(SCREEN_H - MARGIN);
   assign last_obj = obj_idx == 5'(NUM_NESTS) + placed - 5'd1;
   // an undriven (Z) checker output counts as clear
   assign is_hit = hit === 1'b1;

   always_comb begin
      ox = '0;
      oy = '0;
      for (int i = 0; i < NUM_NESTS; i++)
         if (obj_idx == 5'(i)) begin
            ox = nest_x[i];
            oy = nest_y[i];
         end
      for (int i = 0; i < NUM_SUGAR; i++)
         if (obj_idx == 5'(NUM_NESTS + i)) begin
            ox = sugar_x[i];
            oy = sugar_y[i];
         end
   end

   collision_square #(.XW(X_BITS), .YW(Y_BITS), .RW(16)) u_check (
      .check_x(cx),
      .check_y(cy),
      .obj_x  (ox),
      .obj_y  (oy),
      .radius (16'(SPACING)),
      .hit    (hit)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         lfsr        <= SEED_R;
         cx          <= '0;
         cy          <= '0;
         attempts    <= '0;
         obj_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fail        <= 1'b0;
         sugar_x     <= '0;
         sugar_y     <= '0;
         sugar_valid <= '0;
         placed      <= '0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  sugar_valid <= '0;
                  placed      <= '0;
                  fail        <= 1'b0;
                  attempts    <= '0;
                  busy        <= 1'b1;
                  state       <= GEN;
               end
            GEN:
               if (attempts == AW'(MAX_ATTEMPTS)) begin
                  fail  <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  lfsr     <= lfsr_n;
                  cx       <= nx;
                  cy       <= ny;
                  attempts <= attempts + AW'(1);
                  obj_idx  <= '0;
                  state    <= edge_bad ? GEN : CHECK;
               end
            CHECK:
               if (is_hit) state <= GEN;
               else if (last_obj) state <= COMMIT;
               else obj_idx <= obj_idx + 5'd1;
            COMMIT: begin
               for (int i = 0; i < NUM_SUGAR; i++)
                  if (placed == 5'(i)) begin
                     sugar_x[i]     <= cx;
                     sugar_y[i]     <= cy;
                     sugar_valid[i] <= 1'b1;
                  end
               placed <= placed + 5'd1;
               if (placed + 5'd1 == 5'(NUM_SUGAR)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else state <= GEN;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sugar_placer.sv
// tb_sugar_placer: drives placement runs and compares tables, flags and run lengths
// against an algorithmic placement model.
module tb_sugar_placer;
   logic Clk = 1'b0, Reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
   logic [1:0][9:0] na_x, nb_x;
   logic [1:0][8:0] na_y, nb_y;
   logic busy_a, done_a, fail_a, busy_b, done_b, fail_b;
   logic [7:0][9:0] sx_a;
   logic [7:0][8:0] sy_a;
   logic [7:0] sv_a;
   logic [15:0][9:0] sx_b;
   logic [15:0][8:0] sy_b;
   logic [15:0] sv_b;
   logic [4:0] placed_a, placed_b;

   sugar_placer #(.SEED(16'h0001)) dut_a (
      .Clk(Clk), .Reset(Reset), .start(start_a), .nest_x(na_x), .nest_y(na_y),
      .busy(busy_a), .done(done_a), .fail(fail_a), .sugar_x(sx_a), .sugar_y(sy_a),
      .sugar_valid(sv_a), .placed(placed_a));

   sugar_placer #(.NUM_SUGAR(16), .SPACING(200), .MAX_ATTEMPTS(64), .SEED(16'h0000)) dut_b (
      .Clk(Clk), .Reset(Reset), .start(start_b), .nest_x(nb_x), .nest_y(nb_y),
      .busy(busy_b), .done(done_b), .fail(fail_b), .sugar_x(sx_b), .sugar_y(sy_b),
      .sugar_valid(sv_b), .placed(placed_b));

   always #5 Clk = ~Clk;

   int n_cmp = 0, n_bad = 0, run_no = 0;
   int m_x[16], m_y[16], m_placed, m_cyc;
   bit m_fail;
   logic [15:0] lf_a, lf_b;
   logic [7:0][9:0] first_x;
   logic [7:0][8:0] first_y;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return v < 0 ? -v : v;
   endfunction

   // Placement rules replayed candidate by candidate; m_cyc counts cycles spent busy.
   task automatic model_run(inout logic [15:0] lf, input int x0, y0, x1, y1,
                            input int ns, sp, max_att);
      int att, cx, cy, ox, oy;
      bit ok;
      att = 0; m_placed = 0; m_fail = 0; m_cyc = 0;
      forever begin
         m_cyc++;
         if (att == max_att) begin m_fail = 1; break; end
         lf = lf[0] ? (lf >> 1) ^ 16'hB400 : lf >> 1;
         att++;
         cx = int'(lf) % 1024;
         cy = int'(lf) / 128;
         if (cx < 16 || cx >= 624 || cy < 16 || cy >= 464) continue;
         ok = 1;
         for (int k = 0; k < 2 + m_placed; k++) begin
            ox = k == 0 ? x0 : k == 1 ? x1 : m_x[k-2];
            oy = k == 0 ? y0 : k == 1 ? y1 : m_y[k-2];
            m_cyc++;
            if (iabs(cx - ox) < sp && iabs(cy - oy) < sp) begin ok = 0; break; end
         end
         if (!ok) continue;
         m_cyc++;
         m_x[m_placed] = cx;
         m_y[m_placed] = cy;
         m_placed++;
         if (m_placed == ns) break;
      end
   endtask

   task automatic run_a(input int x0, y0, x1, y1, input bit extra);
      int cyc;
      run_no++;
      na_x[0] = 10'(x0); na_y[0] = 9'(y0); na_x[1] = 10'(x1); na_y[1] = 9'(y1);
      model_run(lf_a, x0, y0, x1, y1, 8, 24, 1024);
      @(negedge Clk); start_a = 1'b1;
      @(negedge Clk); start_a = 1'b0;
      check($sformatf("a%0d.busy_rise", run_no), busy_a, 1);
      cyc = 0;
      while (!done_a && cyc < 20000) begin
         cyc++;
         start_a = extra && (cyc == 3 || cyc == 5);
         @(negedge Clk);
      end
      start_a = 1'b0;
      check($sformatf("a%0d.done", run_no), done_a, 1);
      check($sformatf("a%0d.busy_at_done", run_no), busy_a, 0);
      check($sformatf("a%0d.cycles", run_no), cyc, m_cyc);
      check($sformatf("a%0d.fail", run_no), fail_a, m_fail);
      check($sformatf("a%0d.placed", run_no), placed_a, m_placed);
      check($sformatf("a%0d.valid", run_no), sv_a, (1 << m_placed) - 1);
      for (int i = 0; i < m_placed; i++) begin
         check($sformatf("a%0d.x%0d", run_no, i), sx_a[i], m_x[i]);
         check($sformatf("a%0d.y%0d", run_no, i), sy_a[i], m_y[i]);
         check($sformatf("a%0d.in_arena%0d", run_no, i),
               sx_a[i] >= 16 && sx_a[i] < 624 && sy_a[i] >= 16 && sy_a[i] < 464, 1);
         check($sformatf("a%0d.clear_nests%0d", run_no, i),
               (iabs(int'(sx_a[i]) - x0) >= 24 || iabs(int'(sy_a[i]) - y0) >= 24) &&
               (iabs(int'(sx_a[i]) - x1) >= 24 || iabs(int'(sy_a[i]) - y1) >= 24), 1);
         for (int j = 0; j < i; j++)
            check($sformatf("a%0d.apart%0d_%0d", run_no, i, j),
                  iabs(int'(sx_a[i]) - int'(sx_a[j])) >= 24 ||
                  iabs(int'(sy_a[i]) - int'(sy_a[j])) >= 24, 1);
      end
      @(negedge Clk);
      check($sformatf("a%0d.done_pulse", run_no), done_a, 0);
      repeat (3) @(negedge Clk);
      check($sformatf("a%0d.idle_after", run_no), {busy_a, done_a}, 0);
   endtask

   initial begin
      int cyc;
      na_x = '0; na_y = '0; nb_x = '0; nb_y = '0;
      repeat (2) @(negedge Clk);
      check("rst.busy_a", busy_a, 0);
      check("rst.done_fail_a", {done_a, fail_a}, 0);
      check("rst.placed_a", placed_a, 0);
      check("rst.valid_a", sv_a, 0);
      check("rst.table_a", {sx_a, sy_a}, 0);
      check("rst.lfsr_a", dut_a.lfsr, 16'h0001);
      check("rst.lfsr_b_seed0", dut_b.lfsr, 16'hACE1);
      check("rst.b", {busy_b, done_b, fail_b, placed_b, sv_b}, 0);
      Reset = 1'b0;
      lf_a = 16'h0001;
      lf_b = 16'hACE1;

      run_a(100, 100, 540, 380, 1'b1);
      first_x = sx_a;
      first_y = sy_a;
      run_a(100, 100, 540, 380, 1'b0);
      check("rerun_differs", {sx_a, sy_a} != {first_x, first_y}, 1);

      nb_x[0] = 10'd100; nb_y[0] = 9'd100; nb_x[1] = 10'd540; nb_y[1] = 9'd380;
      model_run(lf_b, 100, 100, 540, 380, 16, 200, 64);
      @(negedge Clk); start_b = 1'b1;
      @(negedge Clk); start_b = 1'b0;
      cyc = 0;
      while (!done_b && cyc < 20000) begin cyc++; @(negedge Clk); end
      check("b.done", done_b, 1);
      check("b.cycles", cyc, m_cyc);
      check("b.fail", fail_b, 1);
      check("b.model_fail", fail_b, m_fail);
      check("b.placed_short", placed_b < 16, 1);
      check("b.placed", placed_b, m_placed);
      check("b.valid_contig", sv_b, (1 << placed_b) - 1);
      for (int i = 0; i < m_placed; i++) begin
         check($sformatf("b.x%0d", i), sx_b[i], m_x[i]);
         check($sformatf("b.y%0d", i), sy_b[i], m_y[i]);
      end

      run_a(320, 240, int'($urandom_range(16, 623)), int'($urandom_range(16, 463)), 1'b0);
      for (int r = 0; r < 3; r++)
         run_a(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
               int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b0);

      // reset in the middle of a run, while comparing against the fourth object list
      na_x[0] = 10'd100; na_y[0] = 9'd100; na_x[1] = 10'd540; na_y[1] = 9'd380;
      @(negedge Clk); start_a = 1'b1;
      @(negedge Clk); start_a = 1'b0;
      cyc = 0;
      while (!(placed_a == 5'd3 && dut_a.state == sugar_placer_pkg::CHECK) && cyc < 20000) begin
         cyc++;
         @(negedge Clk);
      end
      check("mid.reached", placed_a == 5'd3 && dut_a.state == sugar_placer_pkg::CHECK, 1);
      Reset = 1'b1;
      #1;
      check("mid.busy", busy_a, 0);
      check("mid.placed", placed_a, 0);
      check("mid.valid", sv_a, 0);
      check("mid.table", {sx_a, sy_a}, 0);
      check("mid.lfsr", dut_a.lfsr, 16'h0001);
      @(negedge Clk);
      Reset = 1'b0;
      lf_a = 16'h0001;
      lf_b = 16'hACE1;
      run_a(100, 100, 540, 380, 1'b0);
      check("post_reset_replay", {sx_a, sy_a}, {first_x, first_y});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
